// File: rtl/echo_timer_pkg.sv
// rtl/echo_timer_pkg.sv - shared state encoding and default parameters for the echo timer
package echo_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK  = 2'd1,
        LISTEN = 2'd2,
        REPORT = 2'd3
    } state_t;

    // 100 MHz / 17.15 kHz: sound covers 2 cm (1 cm out, 1 cm back) per tick, so one tick = 1 cm of range.
    localparam int TICK_DIV_DEF    = 5831;
    localparam int DIST_W_DEF      = 10;
    localparam int BLANK_TICKS_DEF = 20;
    localparam int MAX_TICKS_DEF   = 400;
    localparam int QUAL_CYC_DEF    = 8;
    localparam int CM_PER_TICK     = 1;

endpackage

// File: rtl/echo_sync_qual.sv
// rtl/echo_sync_qual.sv - 2-flop synchronizer plus QUAL_CYC-cycle high-level qualifier for a comparator input
module echo_sync_qual
    import echo_timer_pkg::*;
#(
    parameter int QUAL_CYC = QUAL_CYC_DEF
) (
    input  logic system_clk,
    input  logic reset,
    input  logic echo_in,
    output logic echo_q
);

    localparam int CNT_W = $clog2(QUAL_CYC + 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] qual_cnt;

    always_ff @(posedge system_clk) begin
        if (!reset) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            qual_cnt <= '0;
        end else begin
            sync_1 <= echo_in;
            sync_2 <= sync_1;
            // Saturate so a sustained echo keeps echo_q asserted.
            if (!sync_2) begin
                qual_cnt <= '0;
            end else if (qual_cnt != CNT_W'(QUAL_CYC)) begin
                qual_cnt <= qual_cnt + CNT_W'(1);
            end
        end
    end

    assign echo_q = (qual_cnt == CNT_W'(QUAL_CYC));

endmodule

// File: rtl/echo_timer.sv
// rtl/echo_timer.sv - ultrasonic echo range timer; define ECHO_AVG_EN to average the last 4 results
module echo_timer
    import echo_timer_pkg::*;
#(
    parameter int TICK_DIV    = TICK_DIV_DEF,
    parameter int DIST_W      = DIST_W_DEF,
    parameter int BLANK_TICKS = BLANK_TICKS_DEF,
    parameter int MAX_TICKS   = MAX_TICKS_DEF,
    parameter int QUAL_CYC    = QUAL_CYC_DEF
) (
    input  logic              system_clk,
    input  logic              reset,
    input  logic              burst,
    input  logic              echo_in,
    output logic [DIST_W-1:0] distance_cm,
    output logic              distance_valid,
    output logic              timeout,
    output logic              busy
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t            state;
    state_t            state_next;
    logic              burst_d;
    logic              start;
    logic              echo_q;
    logic              timing;
    logic              tick;
    logic [DIV_W-1:0]  div;
    logic [DIST_W-1:0] tick_cnt;
    logic [DIST_W-1:0] result;
    logic              cnt_clear;
    logic              result_load;
    logic              report_fire;
    logic              timeout_fire;

    echo_sync_qual #(
        .QUAL_CYC (QUAL_CYC)
    ) u_sync_qual (
        .system_clk (system_clk),
        .reset      (reset),
        .echo_in    (echo_in),
        .echo_q     (echo_q)
    );

    assign start  = burst & ~burst_d;
    assign timing = (state == BLANK) || (state == LISTEN);
    assign tick   = timing && (div == DIV_W'(TICK_DIV - 1));
    assign busy   = (state != IDLE);

    always_comb begin
        state_next   = state;
        cnt_clear    = 1'b0;
        result_load  = 1'b0;
        report_fire  = 1'b0;
        timeout_fire = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = BLANK;
                    cnt_clear  = 1'b1;
                end
            end
            BLANK: begin
                if (start) begin
                    cnt_clear = 1'b1;
                end else if (tick && (tick_cnt == DIST_W'(BLANK_TICKS - 1))) begin
                    state_next = LISTEN;
                end
            end
            LISTEN: begin
                // Echo is checked before the timeout so a coincident echo wins.
                if (start) begin
                    state_next = BLANK;
                    cnt_clear  = 1'b1;
                end else if (echo_q) begin
                    state_next  = REPORT;
                    result_load = 1'b1;
                end else if (tick && (tick_cnt == DIST_W'(MAX_TICKS - 1))) begin
                    state_next   = IDLE;
                    timeout_fire = 1'b1;
                end
            end
            REPORT: begin
                state_next  = IDLE;
                report_fire = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (!reset) begin
            state    <= IDLE;
            burst_d  <= 1'b0;
            div      <= '0;
            tick_cnt <= '0;
            result   <= '0;
        end else begin
            state   <= state_next;
            burst_d <= burst;
            if (cnt_clear) begin
                div      <= '0;
                tick_cnt <= '0;
            end else if (timing) begin
                if (tick) begin
                    div      <= '0;
                    tick_cnt <= tick_cnt + DIST_W'(1);
                end else begin
                    div <= div + DIV_W'(1);
                end
            end
            if (result_load) begin
                result <= tick_cnt;
            end
        end
    end

`ifdef ECHO_AVG_EN
    logic [DIST_W-1:0] hist_0;
    logic [DIST_W-1:0] hist_1;
    logic [DIST_W-1:0] hist_2;
    logic [DIST_W-1:0] hist_3;
    logic              avg_pend;
    logic [DIST_W+1:0] hist_sum;

    assign hist_sum = {2'b00, hist_0} + {2'b00, hist_1} + {2'b00, hist_2} + {2'b00, hist_3};

    always_ff @(posedge system_clk) begin
        if (!reset) begin
            hist_0         <= '0;
            hist_1         <= '0;
            hist_2         <= '0;
            hist_3         <= '0;
            avg_pend       <= 1'b0;
            distance_cm    <= '0;
            distance_valid <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            timeout        <= timeout_fire;
            avg_pend       <= report_fire;
            distance_valid <= avg_pend;
            if (report_fire) begin
                hist_0 <= result;
                hist_1 <= hist_0;
                hist_2 <= hist_1;
                hist_3 <= hist_2;
            end
            if (avg_pend) begin
                distance_cm <= DIST_W'(hist_sum >> 2);
            end
        end
    end
`else
    always_ff @(posedge system_clk) begin
        if (!reset) begin
            distance_cm    <= '0;
            distance_valid <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            timeout        <= timeout_fire;
            distance_valid <= report_fire;
            if (report_fire) begin
                distance_cm <= result;
            end
        end
    end
`endif

endmodule

// File: tb/tb_echo_timer.sv
// tb/tb_echo_timer.sv - directed self-checking bench for echo_timer (TICK_DIV=10, BLANK_TICKS=3, MAX_TICKS=50, QUAL_CYC=4)
module tb_echo_timer;

    localparam int DIST_W = 10;

    logic              system_clk = 1'b0;
    logic              reset      = 1'b0;
    logic              burst      = 1'b0;
    logic              echo_in    = 1'b0;
    logic [DIST_W-1:0] distance_cm;
    logic              distance_valid;
    logic              timeout;
    logic              busy;

    int checks      = 0;
    int failures    = 0;
    int valid_cnt   = 0;
    int timeout_cnt = 0;
    int both_cnt    = 0;
    int cyc         = 0;
    int seen_at     = 0;

    always #5 system_clk = ~system_clk;

    echo_timer #(
        .TICK_DIV    (10),
        .DIST_W      (DIST_W),
        .BLANK_TICKS (3),
        .MAX_TICKS   (50),
        .QUAL_CYC    (4)
    ) dut (
        .system_clk     (system_clk),
        .reset          (reset),
        .burst          (burst),
        .echo_in        (echo_in),
        .distance_cm    (distance_cm),
        .distance_valid (distance_valid),
        .timeout        (timeout),
        .busy           (busy)
    );

    always @(negedge system_clk) begin
        if (distance_valid) valid_cnt++;
        if (timeout) timeout_cnt++;
        if (distance_valid && timeout) both_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge system_clk);
        #1;
    endtask

    // Cycle 0 is the edge that samples the burst rising edge.
    task automatic fire_burst();
        burst = 1'b1;
        step(1);
        burst = 1'b0;
        cyc = 0;
    endtask

    task automatic goto(input int k);
        if (k > cyc) step(k - cyc);
        cyc = k;
    endtask

    task automatic clear_counts();
        valid_cnt   = 0;
        timeout_cnt = 0;
    endtask

    task automatic wait_valid(input int budget);
        seen_at = -1;
        for (int i = 0; i < budget; i++) begin
            if (distance_valid) begin
                seen_at = cyc;
                break;
            end
            step(1);
            cyc++;
        end
    endtask

    task automatic wait_timeout(input int budget);
        seen_at = -1;
        for (int i = 0; i < budget; i++) begin
            if (timeout) begin
                seen_at = cyc;
                break;
            end
            step(1);
            cyc++;
        end
    endtask

    task automatic settle();
        echo_in = 1'b0;
        step(12);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(3);
        checks++; if (distance_cm !== 10'd0) begin failures++; $display("FAIL reset_dist: got %0d expected 0", distance_cm); end
        checks++; if (distance_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", distance_valid); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b1;
        step(2);
    endtask

    // Echo sampled at edge k qualifies at k+5, REPORT at k+6, valid at k+7, distance = (k+5)/10.
    task automatic test_basic();
        clear_counts();
        fire_burst();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", busy); end
        goto(199);
        echo_in = 1'b1;
        wait_valid(400);
        checks++; if (seen_at != 207) begin failures++; $display("FAIL basic_latency: got %0d expected 207", seen_at); end
        checks++; if (distance_cm !== 10'd20) begin failures++; $display("FAIL basic_dist: got %0d expected 20", distance_cm); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_done: got %b expected 0", busy); end
        settle();
        checks++; if (valid_cnt != 1) begin failures++; $display("FAIL basic_valid_count: got %0d expected 1", valid_cnt); end
        checks++; if (timeout_cnt != 0) begin failures++; $display("FAIL basic_timeout_count: got %0d expected 0", timeout_cnt); end
    endtask

    task automatic test_timeout();
        clear_counts();
        fire_burst();
        wait_timeout(700);
        checks++; if (seen_at != 500) begin failures++; $display("FAIL timeout_at: got %0d expected 500", seen_at); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy: got %b expected 0", busy); end
        checks++; if (distance_cm !== 10'd20) begin failures++; $display("FAIL timeout_dist_hold: got %0d expected 20", distance_cm); end
        settle();
        checks++; if (timeout_cnt != 1) begin failures++; $display("FAIL timeout_count: got %0d expected 1", timeout_cnt); end
        checks++; if (valid_cnt != 0) begin failures++; $display("FAIL timeout_valid_count: got %0d expected 0", valid_cnt); end
    endtask

    task automatic test_blanking();
        clear_counts();
        fire_burst();
        goto(4);
        echo_in = 1'b1;
        goto(25);
        echo_in = 1'b0;
        goto(119);
        echo_in = 1'b1;
        wait_valid(400);
        checks++; if (seen_at != 127) begin failures++; $display("FAIL blank_latency: got %0d expected 127", seen_at); end
        checks++; if (distance_cm !== 10'd12) begin failures++; $display("FAIL blank_dist: got %0d expected 12", distance_cm); end
        settle();
        checks++; if (valid_cnt != 1) begin failures++; $display("FAIL blank_valid_count: got %0d expected 1", valid_cnt); end
    endtask

    task automatic test_glitch();
        clear_counts();
        fire_burst();
        goto(99);
        echo_in = 1'b1;
        goto(102);
        echo_in = 1'b0;
        goto(299);
        echo_in = 1'b1;
        wait_valid(400);
        checks++; if (seen_at != 307) begin failures++; $display("FAIL glitch_latency: got %0d expected 307", seen_at); end
        checks++; if (distance_cm !== 10'd30) begin failures++; $display("FAIL glitch_dist: got %0d expected 30", distance_cm); end
        settle();
        checks++; if (valid_cnt != 1) begin failures++; $display("FAIL glitch_valid_count: got %0d expected 1", valid_cnt); end
    endtask

    task automatic test_abort();
        clear_counts();
        fire_burst();
        goto(149);
        fire_burst();
        goto(209);
        echo_in = 1'b1;
        wait_valid(400);
        checks++; if (seen_at != 217) begin failures++; $display("FAIL abort_latency: got %0d expected 217", seen_at); end
        checks++; if (distance_cm !== 10'd21) begin failures++; $display("FAIL abort_dist: got %0d expected 21", distance_cm); end
        settle();
        checks++; if (valid_cnt != 1) begin failures++; $display("FAIL abort_valid_count: got %0d expected 1", valid_cnt); end
        checks++; if (timeout_cnt != 0) begin failures++; $display("FAIL abort_timeout_count: got %0d expected 0", timeout_cnt); end
    endtask

    // Echo qualifying in the cycle of the 50th tick wins; one cycle later the timeout wins.
    task automatic test_max_boundary();
        clear_counts();
        fire_burst();
        goto(493);
        echo_in = 1'b1;
        wait_valid(400);
        checks++; if (seen_at != 501) begin failures++; $display("FAIL edge_echo_latency: got %0d expected 501", seen_at); end
        checks++; if (distance_cm !== 10'd49) begin failures++; $display("FAIL edge_echo_dist: got %0d expected 49", distance_cm); end
        settle();
        checks++; if (timeout_cnt != 0) begin failures++; $display("FAIL edge_echo_timeout_count: got %0d expected 0", timeout_cnt); end
        clear_counts();
        fire_burst();
        goto(494);
        echo_in = 1'b1;
        step(1);
        cyc++;
        wait_timeout(100);
        checks++; if (seen_at != 500) begin failures++; $display("FAIL late_echo_timeout_at: got %0d expected 500", seen_at); end
        settle();
        checks++; if (valid_cnt != 0) begin failures++; $display("FAIL late_echo_valid_count: got %0d expected 0", valid_cnt); end
        checks++; if (distance_cm !== 10'd49) begin failures++; $display("FAIL late_echo_dist_hold: got %0d expected 49", distance_cm); end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        fire_burst();
        goto(99);
        reset = 1'b0;
        step(1);
        checks++; if (distance_cm !== 10'd0) begin failures++; $display("FAIL midreset_dist: got %0d expected 0", distance_cm); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (distance_valid !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL midreset_pulses: got valid=%b timeout=%b expected 0 0", distance_valid, timeout); end
        step(2);
        reset = 1'b1;
        step(700);
        checks++; if (valid_cnt != 0 || timeout_cnt != 0) begin failures++; $display("FAIL midreset_no_pulse: got valid=%0d timeout=%0d expected 0 0", valid_cnt, timeout_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_idle: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_blanking();
        test_glitch();
        test_abort();
        test_max_boundary();
        test_reset_mid();
        checks++; if (both_cnt != 0) begin failures++; $display("FAIL valid_timeout_overlap: got %0d expected 0", both_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
